// File: rtl/spi_reg_bank.sv
// spi_reg_bank: oversampled SPI (mode 0) frame decoder writing a bank of 8-bit control registers.
// Optional macro SPI_FRAME_LATCH_EN: stage writes and publish them to regs_flat on frame_start.
module spi_reg_bank #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ssel,
  input  logic                  mosi,
  input  logic                  frame_start,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [AW-1:0]         wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DROP
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ssel_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic sclk_prev;
  logic sclk_rise;
  logic mosi_bit;
  logic ssel_lvl;

  state_t        state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic [AW-1:0] ptr_reg;
  logic          armed;

  logic [7:0] shift_next;
  logic [2:0] cnt_next;
  logic       byte_done;

  logic [7:0] live_mem [NUM_REGS];

  // ssel pipeline resets high so a frame already running at reset release
  // is never mistaken for a fresh one; armed is only set once ssel is seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ssel_sync <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], ssel};
    end
  end

  // Registered edge detect; mosi and ssel are delayed to stay aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      mosi_bit  <= 1'b0;
      ssel_lvl  <= 1'b1;
    end else begin
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      mosi_bit  <= mosi_sync[SYNC_STAGES-1];
      ssel_lvl  <= ssel_sync[SYNC_STAGES-1];
    end
  end

  assign shift_next = {shift_reg[6:0], mosi_bit};
  assign cnt_next   = bit_cnt + {2'b00, sclk_rise};
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      ptr_reg   <= '0;
      armed     <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (!ssel_lvl) begin
        armed <= 1'b1;
      end

      if (state == IDLE) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        if (ssel_lvl && armed) begin
          state <= CMD;
        end
      end else begin
        // A byte completing together with ssel falling is still written.
        if (byte_done && state == DATA) begin
          wr_strobe <= 1'b1;
          wr_addr   <= ptr_reg;
          wr_data   <= shift_next;
          ptr_reg   <= ptr_reg + AW'(1);
        end

        if (!ssel_lvl) begin
          state     <= IDLE;
          shift_reg <= '0;
          bit_cnt   <= '0;
          if (cnt_next != 3'd0) begin
            frame_err <= 1'b1;
          end
        end else if (sclk_rise) begin
          shift_reg <= shift_next;
          bit_cnt   <= cnt_next;
          if (byte_done && state == CMD) begin
            if (shift_next[7]) begin
              ptr_reg <= shift_next[AW-1:0];
              state   <= DATA;
            end else begin
              state <= DROP;
            end
          end
        end
      end
    end
  end

`ifdef SPI_FRAME_LATCH_EN
  logic [7:0] stage_mem [NUM_REGS];

  // Non-blocking update means a write landing with frame_start stays in staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        stage_mem[i] <= '0;
        live_mem[i]  <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          live_mem[i] <= stage_mem[i];
        end
      end
      if (wr_strobe) begin
        stage_mem[wr_addr] <= wr_data;
      end
    end
  end
`else
  logic frame_start_unused;
  assign frame_start_unused = frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_mem[i] <= '0;
      end
    end else if (wr_strobe) begin
      live_mem[wr_addr] <= wr_data;
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_flat[8*gi +: 8] = live_mem[gi];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: table of SPI frames plus hand sequences, strobes checked via a scoreboard queue.
module tb_spi_reg_bank;
  localparam int NUM_REGS = 16;
  localparam int AW       = $clog2(NUM_REGS);
  localparam int SYNC     = 2;
  localparam int LAT      = SYNC + 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sclk = 1'b0;
  logic                  ssel = 1'b0;
  logic                  mosi = 1'b0;
  logic                  frame_start = 1'b0;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_strobe;
  logic [AW-1:0]         wr_addr;
  logic [7:0]            wr_data;
  logic                  frame_err;

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .ssel(ssel),
    .mosi(mosi),
    .frame_start(frame_start),
    .regs_flat(regs_flat),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            due;
  } exp_t;

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    int          extra;
    int          exp_strobes;
    int          exp_errs;
    int          chk_addr;
    logic [7:0]  chk_val;
  } vec_t;

  exp_t       exp_q[$];
  int         err_q[$];
  logic [7:0] model_stage [NUM_REGS];
  logic [7:0] model_live  [NUM_REGS];
  vec_t       vecs [6];
  int         compared = 0;
  int         mismatched = 0;
  int         strobes = 0;
  int         errs = 0;
  bit         fs_on_strobe = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic check_outputs();
    exp_t e;
    int   d;
    if (fs_on_strobe) frame_start = wr_strobe;
    if (wr_strobe) begin
      strobes++;
      if (exp_q.size() == 0) begin
        fail_event("strobe_unexpected", $sformatf("addr %0h data %0h, expected no strobe", wr_addr, wr_data));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        check("strobe_cycle", cyc, e.due);
        $display("write addr=%0h data=%02h cycle=%0d", wr_addr, wr_data, cyc);
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      fail_event("strobe_missing", $sformatf("none, expected addr %0h data %0h at cycle %0d", e.addr, e.data, e.due));
    end
    if (frame_err) begin
      errs++;
      if (err_q.size() == 0) begin
        fail_event("err_unexpected", "frame_err pulse, expected none");
      end else begin
        d = err_q.pop_front();
        check("err_cycle", cyc, d);
        $display("frame_err cycle=%0d", cyc);
      end
    end
    if (err_q.size() > 0 && err_q[0] < cyc) begin
      d = err_q.pop_front();
      fail_event("err_missing", $sformatf("none, expected frame_err at cycle %0d", d));
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = model_live[i];
    return r;
  endfunction

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
`ifdef SPI_FRAME_LATCH_EN
    for (int i = 0; i < NUM_REGS; i++) model_live[i] = model_stage[i];
`endif
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit push, input logic [AW-1:0] addr, input bit drop_ssel);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      mosi = v[7-i];
      tick(4);
      if (i == 7 && drop_ssel) ssel = 1'b0;
      sclk = 1'b1;
      if (i == 7 && push) begin
        e.addr = addr;
        e.data = v;
        e.due  = cyc + LAT;
        exp_q.push_back(e);
        model_stage[addr] = v;
`ifndef SPI_FRAME_LATCH_EN
        model_live[addr] = v;
`endif
      end
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = v[7-i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [31:0] b, input int nb, input int extra, input bit coincide);
    logic [7:0]    cmd;
    logic [7:0]    v;
    logic [AW-1:0] ptr;
    cmd = b[31:24];
    ptr = cmd[AW-1:0];
    ssel = 1'b1;
    tick(6);
    for (int k = 0; k < nb; k++) begin
      v = b[31-8*k -: 8];
      send_byte(v, (k > 0) && cmd[7], ptr, coincide && (k == nb - 1) && (extra == 0));
      if (k > 0 && cmd[7]) ptr = ptr + 1'b1;
    end
    if (extra > 0) send_bits(8'hB5, extra);
    if (!coincide) begin
      tick(6);
      ssel = 1'b0;
      if (extra > 0) err_q.push_back(cyc + LAT);
    end
    tick(12);
  endtask

  initial begin
    vecs[0] = '{32'h83AA5500, 3, 0, 2, 0, 3, 8'hAA};
    vecs[1] = '{32'h8F112200, 3, 0, 2, 0, 0, 8'h22};
    vecs[2] = '{32'h05FF0000, 2, 0, 0, 0, 3, 8'hAA};
    vecs[3] = '{32'h80000000, 1, 5, 0, 1, 4, 8'h55};
    vecs[4] = '{32'h8A010203, 4, 0, 3, 0, 12, 8'h03};
    vecs[5] = '{32'h81C30000, 2, 7, 1, 1, 1, 8'hC3};
    for (int i = 0; i < NUM_REGS; i++) begin
      model_stage[i] = 8'h00;
      model_live[i]  = 8'h00;
    end

    tick(3);
    check("reset_regs", regs_flat, '0);
    check("reset_strobe", wr_strobe, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_addr", wr_addr, '0);
    check("reset_data", wr_data, 8'h00);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 1000; i++) begin
      sclk = 1'($urandom_range(0, 1));
      mosi = 1'($urandom_range(0, 1));
      tick(1);
    end
    sclk = 1'b0;
    tick(10);
    check("idle_strobes", strobes, 0);
    check("idle_errs", errs, 0);
    check("idle_regs", regs_flat, '0);

    for (int v = 0; v < 6; v++) begin
      strobes = 0;
      errs = 0;
      run_frame(vecs[v].bytes, vecs[v].nb, vecs[v].extra, 1'b0);
      pulse_fs();
      check($sformatf("v%0d_strobes", v), strobes, vecs[v].exp_strobes);
      check($sformatf("v%0d_errs", v), errs, vecs[v].exp_errs);
      check($sformatf("v%0d_reg", v), regs_flat[8*vecs[v].chk_addr +: 8], vecs[v].chk_val);
      check($sformatf("v%0d_regs_flat", v), regs_flat, model_flat());
      check($sformatf("v%0d_pending", v), exp_q.size() + err_q.size(), 0);
    end
    check("wrap_reg15", regs_flat[8*15 +: 8], 8'h11);
    check("hold_addr", wr_addr, 4'd1);
    check("hold_data", wr_data, 8'hC3);

    // Last byte completes in the same cycle ssel drops: write, no error.
    strobes = 0;
    errs = 0;
    run_frame(32'h82990000, 2, 0, 1'b1);
    pulse_fs();
    check("coincide_strobes", strobes, 1);
    check("coincide_errs", errs, 0);
    check("coincide_reg2", regs_flat[8*2 +: 8], 8'h99);
    check("coincide_regs_flat", regs_flat, model_flat());

    // Reset in the middle of a frame, then finish that frame.
    ssel = 1'b1;
    tick(6);
    send_byte(8'h81, 1'b0, '0, 1'b0);
    send_bits(8'hA0, 3);
    rst_n = 1'b0;
    #2;
    check("async_reset_regs", regs_flat, '0);
    check("async_reset_addr", wr_addr, '0);
    tick(3);
    exp_q.delete();
    err_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      model_stage[i] = 8'h00;
      model_live[i]  = 8'h00;
    end
    rst_n = 1'b1;
    strobes = 0;
    errs = 0;
    send_bits(8'hF8, 5);
    send_byte(8'hAB, 1'b0, '0, 1'b0);
    tick(6);
    ssel = 1'b0;
    tick(12);
    check("rst_frame_strobes", strobes, 0);
    check("rst_frame_errs", errs, 0);
    run_frame(32'h817E0000, 2, 0, 1'b0);
    pulse_fs();
    check("rst_new_strobes", strobes, 1);
    check("rst_new_reg1", regs_flat[8*1 +: 8], 8'h7E);
    check("rst_new_regs_flat", regs_flat, model_flat());

`ifdef SPI_FRAME_LATCH_EN
    run_frame(32'h823C0000, 2, 0, 1'b0);
    check("latch_reg2_before", regs_flat[8*2 +: 8], 8'h00);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("latch_reg2_after", regs_flat[8*2 +: 8], 8'h3C);
    for (int i = 0; i < NUM_REGS; i++) model_live[i] = model_stage[i];
    tick(2);
    fs_on_strobe = 1'b1;
    run_frame(32'h825A0000, 2, 0, 1'b0);
    fs_on_strobe = 1'b0;
    frame_start = 1'b0;
    check("latch_coincident_hidden", regs_flat[8*2 +: 8], 8'h3C);
    pulse_fs();
    check("latch_coincident_next", regs_flat[8*2 +: 8], 8'h5A);
    check("latch_regs_flat", regs_flat, model_flat());
`endif

    check("final_pending", exp_q.size() + err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

System-clock-domain consumer of the demo's SPI slave link. Oversamples `sclk`/`ssel`/`mosi` into `clk`, assembles bytes and decodes a command/address/data frame. Writes received bytes into a bank of 8-bit control registers that drive the pattern generator. Optionally defers register updates to the next frame boundary so the picture never tears mid-frame.

## Interface
- `NUM_REGS`, 16, number of 8-bit registers; power of two, 2..16; `AW = $clog2(NUM_REGS)`
- `SYNC_STAGES`, 2, synchroniser depth for `sclk`, `ssel` and `mosi`; minimum 2
- `clk` in 1: system clock. One clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock, asynchronous. Mode 0: sampled on rising edge.
- `ssel` in 1: slave select, asynchronous, active-high. Low clears frame state.
- `mosi` in 1: serial data, MSB first.
- `frame_start` in 1: one-`clk` pulse at start of vertical blank.
- `regs_flat` out `NUM_REGS*8`: live register contents; reg i = bits `[8i+7:8i]`.
- `wr_strobe` out 1: one-cycle pulse per data byte written.
- `wr_addr` out `AW`: address of the current write; valid with `wr_strobe`.
- `wr_data` out 8: byte being written; valid with `wr_strobe`.
- `frame_err` out 1: one-cycle pulse when `ssel` drops with a partial byte.

## Operation
- Reset: all registers (staging and live) 0x00, `regs_flat` = 0, `wr_strobe`/`frame_err` = 0, `wr_addr`/`wr_data` = 0, state IDLE, bit count 0.
- Synchronise each input through `SYNC_STAGES` flops. Rising `sclk` edge = synced sclk 1 with previous sample 0. Requires f_sclk ≤ f_clk/4.
- FSM states:
  - IDLE: waits for synced `ssel`=1, then enters CMD.
  - CMD: on each sclk rising edge, shift `mosi` into an 8-bit shifter and increment a 3-bit bit count. On the 8th bit:
    - bit7=1: load address pointer from `cmd[AW-1:0]`, go to DATA.
    - bit7=0: go to DROP (no-op frame).
    - bits [6:AW] are ignored.
  - DATA: assembles bytes the same way. On each 8th bit, write the byte to the pointer address, pulse `wr_strobe`, then pointer += 1 mod `NUM_REGS` (wraps 15 → 0 at 16 regs). Unlimited bytes per frame.
  - DROP: shifts and discards until `ssel` falls.
- Synced `ssel` falling in any non-IDLE state:
  - Return to IDLE and clear the shifter and bit count.
  - If bit count ≠ 0, pulse `frame_err`; the partial byte is discarded and no write occurs.
- Synced `ssel` low in IDLE holds all frame state cleared.
- Async `rst_n` assertion mid-frame clears everything immediately. After release, the block waits for a fresh `ssel` rising edge. A frame already in progress at release is ignored until `ssel` drops.

## Timing
- Latency: the 8th sclk rising edge at the pins produces a `wr_strobe` high exactly `SYNC_STAGES+2` `clk` cycles later (sync stages, edge detect, strobe register).
- The register write takes effect on the clock edge ending the `wr_strobe` cycle. `wr_addr`/`wr_data` are held until the next strobe.
- `frame_err` asserts `SYNC_STAGES+2` cycles after the `ssel` falling edge at the pin.
- `wr_strobe` and `frame_err` never coincide. A byte completed in the same sync cycle as `ssel` falling is written (the edge wins), and no error is flagged.

## Configuration
- `SPI_FRAME_LATCH_EN` defined:
  - Writes go to a staging bank; `regs_flat` shows the live bank.
  - On `frame_start`, live ← staging, visible the next cycle.
  - A write in the same cycle as `frame_start` lands in staging only; it appears at the following `frame_start`.
- `SPI_FRAME_LATCH_EN` undefined:
  - No staging bank; writes update `regs_flat` directly, visible the cycle after `wr_strobe`.
  - `frame_start` is ignored.

## Test plan
- Reset then idle: `regs_flat` = 0, no strobes for 1000 cycles with random `sclk` while `ssel`=0.
- Frame 0x83,0xAA,0x55: `wr_strobe` twice, (addr 3, 0xAA) then (addr 4, 0x55). Each strobe occurs `SYNC_STAGES+2` cycles after the 8th sclk edge of its byte. Final reg3=0xAA, reg4=0x55.
- Wrap: frame 0x8F,0x11,0x22 with `NUM_REGS`=16 gives reg15=0x11, reg0=0x22.
- No-op and abort:
  - Frame 0x05,0xFF gives no strobes and no register change.
  - Frame 0x80 plus 5 bits then `ssel` low gives one `frame_err` pulse and no write.
- With `SPI_FRAME_LATCH_EN`: write reg2=0x3C; `regs_flat` reg2 stays 0x00 until a `frame_start` pulse, then reads 0x3C the next cycle. A write coincident with `frame_start` is not visible until the next pulse.
- Reset mid-frame: drop `rst_n` after 0x81 plus 3 bits. All registers read 0. The rest of that frame produces no strobes; a new frame 0x81,0x7E writes reg1=0x7E.
